// File: rtl/riscv_core_mdu.sv
// riscv_core_mdu -- iterative RV64M/RV32M multiply/divide unit.
//
// Sits beside the single-cycle ALU in execute. Multiplies use a radix-2
// shift-add on operand magnitudes and divides use restoring division on
// magnitudes. One bit is retired per clock, with a sign fixup on the last
// iteration. Word (W) ops work on the low 32 bits and sign-extend the
// 32-bit result. Divide-by-zero, signed overflow and illegal word ops
// produce their architectural results directly.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_mdu_valid/o_mdu_ready  request handshake (ready only while idle)
//   i_mdu_op              funct3 (MUL..REMU)
//   i_mdu_isword          W variant (ignored when XLEN=32)
//   i_mdu_srcA/i_mdu_srcB rs1 / rs2 operands
//   o_mdu_valid/i_mdu_ready  result handshake, result held until consumed
//   o_mdu_result          result
//   o_mdu_busy            high while an operation is in flight or unconsumed
module riscv_core_mdu #(
  parameter int XLEN          = 64,
  parameter bit EARLY_SPECIAL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_mdu_valid,
  output logic            o_mdu_ready,
  input  logic [2:0]      i_mdu_op,
  input  logic            i_mdu_isword,
  input  logic [XLEN-1:0] i_mdu_srcA,
  input  logic [XLEN-1:0] i_mdu_srcB,
  output logic            o_mdu_valid,
  input  logic            i_mdu_ready,
  output logic [XLEN-1:0] o_mdu_result,
  output logic            o_mdu_busy
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN);
  localparam logic [CW-1:0]   CNT_WORD = CW'(32);
  localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

  // Two's-complement negation at XLEN width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + {{(XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Two's-complement negation of a full double-width product.
  function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v);
    return (~v) + {{(2*XLEN-1){1'b0}}, 1'b1};
  endfunction

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  // Zero-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{1'b0}};
    r[31:0] = v;
    return r;
  endfunction

  // Control and result registers
  logic [1:0]      state_r;
  logic [CW-1:0]   cnt_r;
  logic [2:0]      op_r;
  logic            isword_r;
  logic            neg_r;      // negate product / quotient
  logic            rneg_r;     // negate remainder (dividend sign)
  logic            special_r;  // div-by-zero / overflow running the long way
  logic [XLEN-1:0] spec_r;
  logic            ready_r;
  logic            valid_r;
  logic            busy_r;
  logic [XLEN-1:0] result_r;

  // Datapath registers. Multiply: x_r = shifted multiplicand, y_r =
  // multiplier shifting right, acc_r = product. Divide: x_r[XLEN-1:0] =
  // divisor, y_r = dividend shifting out / quotient shifting in,
  // acc_r[XLEN-1:0] = partial remainder.
  logic [2*XLEN-1:0] x_r;
  logic [XLEN-1:0]   y_r;
  logic [2*XLEN-1:0] acc_r;

  logic            isword_in_s;
  logic            accept_s;
  logic            sgn_a_s;
  logic            sgn_b_s;
  logic [XLEN-1:0] a_ext_s;
  logic [XLEN-1:0] b_ext_s;
  logic            neg_a_s;
  logic            neg_b_s;
  logic [XLEN-1:0] mag_a_s;
  logic [XLEN-1:0] mag_b_s;
  logic [XLEN-1:0] min_s;
  logic            illegal_s;
  logic            div0_s;
  logic            ovf_s;
  logic            special_s;
  logic            early_s;
  logic [XLEN-1:0] spec_res_s;
  logic [1:0]      state_nxt_s;

  logic [2*XLEN-1:0] x_step_s;
  logic [XLEN-1:0]   y_step_s;
  logic [2*XLEN-1:0] acc_step_s;
  logic [XLEN:0]     div_try_s;
  logic [XLEN:0]     div_sub_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   raw_s;
  logic [XLEN-1:0]   final_s;

  assign isword_in_s = (XLEN == 64) ? i_mdu_isword : 1'b0;
  assign accept_s    = i_mdu_valid & ready_r;

  assign o_mdu_ready  = ready_r;
  assign o_mdu_valid  = valid_r;
  assign o_mdu_busy   = busy_r;
  assign o_mdu_result = result_r;

  // Operand signedness from funct3 (MUL and the unsigned ops need none).
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (i_mdu_op)
      3'b001, 3'b100, 3'b110: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b1;
      end
      3'b010: begin
        sgn_a_s = 1'b1;
        sgn_b_s = 1'b0;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
  end

  // Extend the operands to XLEN and take their magnitudes.
  always_comb begin
    a_ext_s = i_mdu_srcA;
    b_ext_s = i_mdu_srcB;
    if (isword_in_s) begin
      if (sgn_a_s) begin
        a_ext_s = sext32(i_mdu_srcA[31:0]);
      end else begin
        a_ext_s = zext32(i_mdu_srcA[31:0]);
      end
      if (sgn_b_s) begin
        b_ext_s = sext32(i_mdu_srcB[31:0]);
      end else begin
        b_ext_s = zext32(i_mdu_srcB[31:0]);
      end
    end else begin
      a_ext_s = i_mdu_srcA;
      b_ext_s = i_mdu_srcB;
    end
    neg_a_s = sgn_a_s & a_ext_s[XLEN-1];
    neg_b_s = sgn_b_s & b_ext_s[XLEN-1];
    mag_a_s = neg_a_s ? neg_x(a_ext_s) : a_ext_s;
    mag_b_s = neg_b_s ? neg_x(b_ext_s) : b_ext_s;
  end

  // Detect the cases with a fixed architectural answer.
  always_comb begin
    min_s     = isword_in_s ? sext32(32'h8000_0000) : MIN_X;
    illegal_s = isword_in_s & ~i_mdu_op[2] & (i_mdu_op[1:0] != 2'b00);
    div0_s    = i_mdu_op[2] & (b_ext_s == ZERO_X);
    ovf_s     = i_mdu_op[2] & ~i_mdu_op[0] & (a_ext_s == min_s) & (b_ext_s == ONES_X);
    special_s = div0_s | ovf_s;
    early_s   = illegal_s | (special_s & EARLY_SPECIAL);
  end

  // Architectural result for illegal, divide-by-zero and overflow cases.
  always_comb begin
    spec_res_s = ZERO_X;
    if (illegal_s) begin
      spec_res_s = ZERO_X;
    end else if (div0_s) begin
      if (i_mdu_op[1]) begin
        spec_res_s = isword_in_s ? sext32(i_mdu_srcA[31:0]) : i_mdu_srcA;
      end else begin
        spec_res_s = ONES_X;
      end
    end else if (ovf_s) begin
      if (i_mdu_op[1]) begin
        spec_res_s = ZERO_X;
      end else begin
        spec_res_s = a_ext_s;
      end
    end else begin
      spec_res_s = ZERO_X;
    end
  end

  // One radix-2 iteration of the selected operation.
  always_comb begin
    x_step_s   = x_r;
    y_step_s   = y_r;
    acc_step_s = acc_r;
    div_try_s  = {acc_r[XLEN-1:0], y_r[XLEN-1]};
    div_sub_s  = div_try_s - {1'b0, x_r[XLEN-1:0]};
    if (op_r[2]) begin
      // Bit XLEN of the difference is the borrow: set means the trial
      // subtraction fails and the shifted remainder is kept.
      if (!div_sub_s[XLEN]) begin
        acc_step_s = {{XLEN{1'b0}}, div_sub_s[XLEN-1:0]};
        y_step_s   = {y_r[XLEN-2:0], 1'b1};
      end else begin
        acc_step_s = {{XLEN{1'b0}}, div_try_s[XLEN-1:0]};
        y_step_s   = {y_r[XLEN-2:0], 1'b0};
      end
    end else begin
      if (y_r[0]) begin
        acc_step_s = acc_r + x_r;
      end else begin
        acc_step_s = acc_r;
      end
      x_step_s = {x_r[2*XLEN-2:0], 1'b0};
      y_step_s = {1'b0, y_r[XLEN-1:1]};
    end
  end

  // Sign fixup and result selection from the last iteration's values.
  always_comb begin
    prod_s = neg_r ? neg_p(acc_step_s) : acc_step_s;
    quo_s  = neg_r ? neg_x(y_step_s) : y_step_s;
    rem_s  = rneg_r ? neg_x(acc_step_s[XLEN-1:0]) : acc_step_s[XLEN-1:0];
    case (op_r)
      3'b000:                 raw_s = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: raw_s = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         raw_s = quo_s;
      3'b110, 3'b111:         raw_s = rem_s;
      default:                raw_s = ZERO_X;
    endcase
    if (special_r) begin
      final_s = spec_r;
    end else if (isword_r) begin
      final_s = sext32(raw_s[31:0]);
    end else begin
      final_s = raw_s;
    end
  end

  // FSM next state: IDLE -> CALC/DONE on accept, CALC -> DONE at count 1,
  // DONE -> IDLE on consumer handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = early_s ? ST_DONE : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (i_mdu_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, handshake outputs, operand capture and iteration registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      op_r      <= 3'b000;
      isword_r  <= 1'b0;
      neg_r     <= 1'b0;
      rneg_r    <= 1'b0;
      special_r <= 1'b0;
      spec_r    <= ZERO_X;
      ready_r   <= 1'b1;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      result_r  <= ZERO_X;
      x_r       <= {(2*XLEN){1'b0}};
      y_r       <= ZERO_X;
      acc_r     <= {(2*XLEN){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s != ST_IDLE);
      valid_r <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r      <= i_mdu_op;
            isword_r  <= isword_in_s;
            neg_r     <= neg_a_s ^ neg_b_s;
            rneg_r    <= neg_a_s;
            special_r <= special_s;
            spec_r    <= spec_res_s;
            cnt_r     <= isword_in_s ? CNT_WORD : CNT_FULL;
            acc_r     <= {(2*XLEN){1'b0}};
            if (i_mdu_op[2]) begin
              // Word dividends are left-aligned so the first 32 shifts
              // feed their bits into the remainder.
              x_r <= {ZERO_X, mag_b_s};
              y_r <= isword_in_s ? (mag_a_s << (XLEN - 32)) : mag_a_s;
            end else begin
              x_r <= {ZERO_X, mag_a_s};
              y_r <= mag_b_s;
            end
            if (early_s) begin
              result_r <= spec_res_s;
            end else begin
              result_r <= result_r;
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        ST_CALC: begin
          x_r   <= x_step_s;
          y_r   <= y_step_s;
          acc_r <= acc_step_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            result_r <= final_s;
          end else begin
            result_r <= result_r;
          end
        end
        ST_DONE: begin
          result_r <= result_r;
        end
        default: begin
          result_r <= result_r;
        end
      endcase
    end
  end

endmodule

// File: doc/riscv_core_mdu.md
Name: riscv_core_mdu

Overview:
Iterative multiply/divide unit implementing the RV64M/RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, plus the W variants). It sits beside the single-cycle integer ALU in the execute stage and is parametrised in XLEN. It uses a valid/ready handshake on both sides and a multi-cycle radix-2 datapath, so execute stalls while it is busy. Word ops use the ALU convention: operate on the low 32 bits and sign-extend the 32-bit result to XLEN.

Parameters:
XLEN, 64, datapath width (32 or 64); XLEN=32 forces i_mdu_isword to be ignored.
EARLY_SPECIAL, 1, if 1 the divide-by-zero and overflow cases complete in 1 cycle; if 0 they run the full iteration and give the same results.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_mdu_valid  input  1  operation request
o_mdu_ready  output  1  unit can accept (high only in IDLE)
i_mdu_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
i_mdu_isword  input  1  W variant (32-bit op, sign-extended result)
i_mdu_srcA  input  XLEN  rs1 / multiplicand / dividend
i_mdu_srcB  input  XLEN  rs2 / multiplier / divisor
o_mdu_valid  output  1  result available
i_mdu_ready  input  1  consumer accepts result
o_mdu_result  output  XLEN  result
o_mdu_busy  output  1  high in CALC or DONE

Behaviour:
- Reset is asynchronous and active-low. On i_rst_n low: state=IDLE, o_mdu_valid=0, o_mdu_result=0, o_mdu_ready=1, o_mdu_busy=0, all internal registers 0.
- A reset mid-operation aborts the operation; no result is produced.
- FSM states are IDLE, CALC and DONE.
- IDLE: o_mdu_ready=1. On i_mdu_valid&&o_mdu_ready, capture op, isword and operands.
  - Special case with EARLY_SPECIAL=1, or illegal word op: load the result and go to DONE.
  - Otherwise: go to CALC with the iteration counter set to N (N=32 if isword else XLEN).
- CALC: one bit per cycle; the counter decrements each cycle. At count 1 the final result (including sign fixup) is registered and the FSM goes to DONE.
- Latency: o_mdu_valid rises exactly N+1 clock edges after the accept edge (65 for XLEN=64 non-word, 33 for word). Special cases rise 1 edge after accept.
- DONE: o_mdu_valid=1 and o_mdu_result is held stable until i_mdu_ready=1. That edge returns the FSM to IDLE.
- No new accept occurs in the same cycle as result handoff, so back-to-back throughput is one op per N+2 cycles.
- Inputs are ignored outside IDLE. i_mdu_valid may drop without effect while the unit is busy.
- Multiply: shift-add on operand magnitudes into a 2*XLEN product, then conditional negation.
  - Sign rules: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned×unsigned.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide: restoring division on magnitudes.
  - Signed quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Word ops: the operands are srcA[31:0] and srcB[31:0], with sign- or zero-extension per op.
  - The result is {{32{r[31]}}, r[31:0]}.
  - Legal word ops are MULW, DIVW, DIVUW, REMW and REMUW.
  - isword with op 001/010/011 is illegal and returns 0 with 1-cycle latency.
- Divide by zero: quotient = all ones (the word form sign-extends to all ones); remainder = dividend (word: sign-extended low 32 bits).
- Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
- o_mdu_busy = (state != IDLE).

Test Plan:
- MUL srcA=7, srcB=0xFFFF_FFFF_FFFF_FFFD (-3): o_mdu_valid asserts 65 edges after accept with result 0xFFFF_FFFF_FFFF_FFEB. MULHU with both operands all-ones returns 0xFFFF_FFFF_FFFF_FFFE; MULH with the same operands returns 0; MULHSU with srcA=-1, srcB=2 returns all ones.
- DIV -7/2 returns 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7/2 returns all ones (-1); DIVU 100/7 returns 14; REMU 100/7 returns 2. Each completes with 65-cycle latency.
- DIVU 5/0 returns all ones and REMU 5/0 returns 5. DIV 0x8000_0000_0000_0000 / -1 returns 0x8000_0000_0000_0000 and REM of the same returns 0. Each completes with 1-cycle latency when EARLY_SPECIAL=1.
- DIVW srcA=0x0000_0001_8000_0000, srcB=all ones returns 0xFFFF_FFFF_8000_0000. MULW 0x10000×0x10000 returns 0. MULW 0x7FFF_FFFF×2 returns 0xFFFF_FFFF_FFFF_FFFE. All complete with 33-cycle latency.
- Backpressure: hold i_mdu_ready=0 for 5 cycles in DONE. o_mdu_valid and o_mdu_result stay stable and o_mdu_ready stays 0; i_mdu_valid pulses during this window are ignored. One cycle after i_mdu_ready=1, o_mdu_ready=1.
- Pull i_rst_n low at iteration 20 of a DIV. o_mdu_valid=0, o_mdu_result=0 and o_mdu_ready=1 immediately, without waiting for a clock edge. After release, a fresh MUL 3×4 returns 12.
